muldiv_arbiter: RTL and testbench
=================================

Name: muldiv_arbiter

Overview:
- Shares one iterative CompMultiplier-style unit among N requesters. The unit has a Run/Reset/Ready handshake and a 64-bit Product_out.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the unit's reset, load and run, then returns the 64-bit product with a one-cycle done pulse to the winner.
- Sits between the processor-side requesters (ALU, test sequencer) and the single shared multiplier.

Parameters:
- N, 4, number of requesters (2..8).
- W, 32, operand width; the product is 2*W bits.
- TIMEOUT, 256, max cycles allowed in RUN (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request level; held until that requester's done.
- a_in  input  N*W  packed multiplicands; slice i = a_in[i*W +: W].
- b_in  input  N*W  packed multipliers; slice i = b_in[i*W +: W].
- gnt  output  N  one-hot grant; high from LOAD through DONE.
- done  output  N  one-hot, one-cycle completion pulse.
- result  output  2*W  product of the last completed operation.
- err  output  1  timeout flag (see Optional Feature).
- busy  output  1  high in any state other than IDLE.
- mu_reset  output  1  active-high reset to the shared unit.
- mu_run  output  1  Run to the shared unit.
- mu_multiplicand  output  W  latched operand A.
- mu_multiplier  output  W  latched operand B.
- mu_product  input  2*W  unit Product_out.
- mu_ready  input  1  unit Ready.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, gnt=0, done=0, result=0, err=0, busy=0, mu_reset=1, mu_run=0, operand registers=0, rr pointer=0, ready_q=0. A mid-operation reset aborts immediately; no done is issued.
- All outputs are registered.
- FSM states: IDLE, LOAD, CLR, RUN, DONE.
- IDLE:
  - mu_reset=1, mu_run=0.
  - If any req bit is set, pick the first set bit searching upward from the rr pointer, wrapping modulo N.
  - Latch that requester's a/b slices into the mu_* operand registers, set gnt one-hot, go to LOAD.
- LOAD (1 cycle): mu_reset=1 with operands stable, so the unit loads them. Go to CLR.
- CLR (1 cycle): mu_reset=0, mu_run=0. Go to RUN.
- RUN:
  - mu_run=1.
  - ready_q holds mu_ready from the previous cycle.
  - Completion is the rising edge (mu_ready=1 and ready_q=0). A Ready level left over from a prior op is ignored.
  - On completion: capture mu_product into result, drop mu_run, go to DONE.
- DONE (1 cycle):
  - done[winner]=1.
  - Set rr pointer to winner+1 mod N.
  - Then: gnt=0, mu_reset=1, go to IDLE.
- result holds its value until the next DONE.
- Minimum latency from req sampled in IDLE to done is 4 cycles plus the unit's run time.
- Operands are latched once at grant. Later changes to a_in/b_in have no effect on the operation in flight.
- A req dropped while granted does not abort: the operation completes and done still pulses.
- A requester re-asserting req in the cycle after its done is served again only after the other pending requesters, per the rr rotation.
- Simultaneous requests are served strictly in rr order. No requester waits more than N-1 operations.
- Operands are unsigned; the width rules belong to the unit. The arbiter passes mu_product through unmodified.
- Invalid state encoding recovers to IDLE with mu_reset=1.

Optional Feature:
- Macro: MULDIV_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to RUN.
  - If it reaches TIMEOUT with no Ready edge: set err=1 (sticky until Reset), set result to all ones, pulse done[winner], advance rr, return to IDLE with mu_reset=1.
- Not defined: no counter; err is tied 0; RUN waits indefinitely.

Test Plan:
- Single requester:
  - Stimulus: req=0001, a=32'd7, b=32'd6.
  - Required: gnt=0001 through DONE, mu_reset high in LOAD then low in CLR; done[0] one cycle; result=64'd42; busy low afterward.
- All requesting:
  - Stimulus: req=1111 held, operands per requester i: a=i+1, b=10.
  - Required: done order 0,1,2,3 then 0 again; results 10, 20, 30, 40.
- Rotation fairness:
  - Stimulus: after requester 2 served, req=0101.
  - Required: requester 0 granted before 2 (pointer at 3 wraps to 0).
- Operand change and req withdrawal:
  - Stimulus: a=32'hFFFFFFFF, b=32'hFFFFFFFF; change a to 0 and drop req during RUN.
  - Required: result=64'hFFFFFFFE00000001; done still pulses.
- Reset mid-operation:
  - Stimulus: Reset low during RUN.
  - Required: immediately gnt=0, mu_run=0, mu_reset=1, result=0, no done. After release, a pending req starts a fresh op and rr pointer=0.
- Timeout (macro defined, TIMEOUT=8):
  - Stimulus: mu_ready tied 0.
  - Required: done pulses 8 cycles after RUN entry; err=1; result=all ones. Without the macro, the bench sees busy stay high.

Source files
------------

// File: rtl/muldiv_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared iterative multiplier.
// req is a level held by a requester until its one-cycle done pulse; gnt marks the operation in flight.
interface muldiv_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [2*W-1:0] result;
  logic           err;
  logic           busy;
  logic           mu_reset;
  logic           mu_run;
  logic [W-1:0]   mu_multiplicand;
  logic [W-1:0]   mu_multiplier;
  logic [2*W-1:0] mu_product;
  logic           mu_ready;

  modport master (
    output req, a_in, b_in, mu_product, mu_ready,
    input  gnt, done, result, err, busy, mu_reset, mu_run, mu_multiplicand, mu_multiplier
  );

  modport slave (
    input  req, a_in, b_in, mu_product, mu_ready,
    output gnt, done, result, err, busy, mu_reset, mu_run, mu_multiplicand, mu_multiplier
  );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among N requesters.
// Optional RUN watchdog enabled by MULDIV_ARB_TIMEOUT_EN (err, all-ones result on expiry).
module muldiv_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  muldiv_arbiter_if.slave  bus,
  output logic [2:0]       o_dbg_state
);
  localparam int PW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CLR  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         r_state, w_state_n;
  logic [N-1:0]   r_gnt, w_gnt_n;
  logic [N-1:0]   r_done, w_done_n;
  logic [2*W-1:0] r_result, w_result_n;
  logic           r_busy, w_busy_n;
  logic           r_mu_reset, w_mu_reset_n;
  logic           r_mu_run, w_mu_run_n;
  logic [W-1:0]   r_a, w_a_n;
  logic [W-1:0]   r_b, w_b_n;
  logic [PW-1:0]  r_rr, w_rr_n;
  logic [PW-1:0]  r_win, w_win_n;
  logic           r_ready_q;
  logic           w_ready_edge;
  logic           w_found;
  logic [PW-1:0]  w_pick;
  logic [W-1:0]   w_pick_a, w_pick_b;

  // An empty marker scope appears only when the parameters are out of range.
  if (N < 2 || N > 8 || TIMEOUT < 2) begin : g_bad_params
  end

`ifdef MULDIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_err, w_err_n;
`endif

  // First set request at or above the rotation pointer, wrapping modulo N.
  always_comb begin
    w_found  = 1'b0;
    w_pick   = '0;
    w_pick_a = '0;
    w_pick_b = '0;
    for (int k = 0; k < N; k++) begin
      automatic int idx = int'(r_rr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && bus.req[idx]) begin
        w_found  = 1'b1;
        w_pick   = PW'(idx);
        w_pick_a = bus.a_in[idx*W +: W];
        w_pick_b = bus.b_in[idx*W +: W];
      end
    end
  end

  assign w_ready_edge = bus.mu_ready && !r_ready_q;

  always_comb begin
    w_state_n    = r_state;
    w_gnt_n      = r_gnt;
    w_done_n     = '0;
    w_result_n   = r_result;
    w_mu_reset_n = r_mu_reset;
    w_mu_run_n   = r_mu_run;
    w_a_n        = r_a;
    w_b_n        = r_b;
    w_rr_n       = r_rr;
    w_win_n      = r_win;
`ifdef MULDIV_ARB_TIMEOUT_EN
    w_cnt_n      = r_cnt;
    w_err_n      = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_mu_reset_n = 1'b1;
        w_mu_run_n   = 1'b0;
        w_gnt_n      = '0;
        if (w_found) begin
          w_state_n = S_LOAD;
          w_gnt_n   = {{(N-1){1'b0}}, 1'b1} << w_pick;
          w_a_n     = w_pick_a;
          w_b_n     = w_pick_b;
          w_win_n   = w_pick;
        end
      end
      S_LOAD: begin
        w_state_n    = S_CLR;
        w_mu_reset_n = 1'b0;
        w_mu_run_n   = 1'b0;
      end
      S_CLR: begin
        w_state_n  = S_RUN;
        w_mu_run_n = 1'b1;
`ifdef MULDIV_ARB_TIMEOUT_EN
        w_cnt_n    = '0;
`endif
      end
      S_RUN: begin
        if (w_ready_edge) begin
          w_state_n  = S_DONE;
          w_result_n = bus.mu_product;
          w_mu_run_n = 1'b0;
          w_done_n   = r_gnt;
        end
`ifdef MULDIV_ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_n  = S_DONE;
          w_result_n = '1;
          w_mu_run_n = 1'b0;
          w_done_n   = r_gnt;
          w_err_n    = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_state_n    = S_IDLE;
        w_gnt_n      = '0;
        w_mu_reset_n = 1'b1;
        w_mu_run_n   = 1'b0;
        w_rr_n       = (r_win == PW'(N - 1)) ? '0 : r_win + 1'b1;
      end
      default: begin
        w_state_n    = S_IDLE;
        w_gnt_n      = '0;
        w_mu_reset_n = 1'b1;
        w_mu_run_n   = 1'b0;
      end
    endcase
    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_done     <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_mu_reset <= 1'b1;
      r_mu_run   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_rr       <= '0;
      r_win      <= '0;
      r_ready_q  <= 1'b0;
`ifdef MULDIV_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_gnt      <= w_gnt_n;
      r_done     <= w_done_n;
      r_result   <= w_result_n;
      r_busy     <= w_busy_n;
      r_mu_reset <= w_mu_reset_n;
      r_mu_run   <= w_mu_run_n;
      r_a        <= w_a_n;
      r_b        <= w_b_n;
      r_rr       <= w_rr_n;
      r_win      <= w_win_n;
      r_ready_q  <= bus.mu_ready;
`ifdef MULDIV_ARB_TIMEOUT_EN
      r_cnt      <= w_cnt_n;
      r_err      <= w_err_n;
`endif
    end
  end

  assign bus.gnt             = r_gnt;
  assign bus.done            = r_done;
  assign bus.result          = r_result;
  assign bus.busy            = r_busy;
  assign bus.mu_reset        = r_mu_reset;
  assign bus.mu_run          = r_mu_run;
  assign bus.mu_multiplicand = r_a;
  assign bus.mu_multiplier   = r_b;
  assign o_dbg_state         = r_state;
`ifdef MULDIV_ARB_TIMEOUT_EN
  assign bus.err             = r_err;
`else
  assign bus.err             = 1'b0;
`endif
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a behavioural iterative multiplier model.
module tb_muldiv_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int TIMEOUT = 8;
  localparam int RUN_LAT = 5;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  logic       unit_stall;
  int         vec_cnt;
  int         err_cnt;
  logic [2*W-1:0] exp_q[$];

  muldiv_arbiter_if #(.N(N), .W(W)) bus ();

  muldiv_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier model: loads operands while held in reset, Ready rises RUN_LAT cycles into Run.
  logic [2*W-1:0] u_a, u_b;
  int             u_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_a <= '0; u_b <= '0; u_cnt <= 0;
      bus.mu_ready <= 1'b0; bus.mu_product <= '0;
    end else if (bus.mu_reset) begin
      u_a <= {{W{1'b0}}, bus.mu_multiplicand};
      u_b <= {{W{1'b0}}, bus.mu_multiplier};
      u_cnt <= 0;
      bus.mu_ready <= 1'b0;
    end else if (bus.mu_run && !bus.mu_ready && !unit_stall) begin
      if (u_cnt == RUN_LAT - 1) begin
        bus.mu_product <= u_a * u_b;
        bus.mu_ready <= 1'b1;
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end

  // driver tasks
  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output logic [N-1:0] d);
    d = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        d = bus.done;
        break;
      end
    end
  endtask

  task automatic wait_run(input int budget, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.mu_run) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({bus.gnt, bus.done} !== 8'h00) begin err_cnt++; $display("FAIL reset_gnt_done: got %h expected 00", {bus.gnt, bus.done}); end
    vec_cnt++; if (bus.result !== 64'd0) begin err_cnt++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    vec_cnt++; if ({bus.err, bus.busy, bus.mu_reset, bus.mu_run} !== 4'b0010) begin err_cnt++; $display("FAIL reset_ctrl: got %b expected 0010", {bus.err, bus.busy, bus.mu_reset, bus.mu_run}); end
    vec_cnt++; if ({bus.mu_multiplicand, bus.mu_multiplier} !== 64'd0) begin err_cnt++; $display("FAIL reset_operands: got %h expected 0", {bus.mu_multiplicand, bus.mu_multiplier}); end
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0] d;
    do_reset();
    set_op(0, 32'd7, 32'd6);
    bus.req = 4'b0001;
    @(negedge clk);
    vec_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL single_load_gnt: got %b expected 0001", bus.gnt); end
    vec_cnt++; if ({bus.mu_reset, bus.mu_run, bus.busy} !== 3'b101) begin err_cnt++; $display("FAIL single_load_ctrl: got %b expected 101", {bus.mu_reset, bus.mu_run, bus.busy}); end
    vec_cnt++; if ({bus.mu_multiplicand, bus.mu_multiplier} !== {32'd7, 32'd6}) begin err_cnt++; $display("FAIL single_operands: got %h expected 0000000700000006", {bus.mu_multiplicand, bus.mu_multiplier}); end
    @(negedge clk);
    vec_cnt++; if ({bus.mu_reset, bus.mu_run, bus.gnt} !== 6'b000001) begin err_cnt++; $display("FAIL single_clr: got %b expected 000001", {bus.mu_reset, bus.mu_run, bus.gnt}); end
    @(negedge clk);
    vec_cnt++; if (bus.mu_run !== 1'b1) begin err_cnt++; $display("FAIL single_run: got %b expected 1", bus.mu_run); end
    wait_done(40, d);
    bus.req = '0;
    vec_cnt++; if (d !== 4'b0001) begin err_cnt++; $display("FAIL single_done: got %b expected 0001", d); end
    vec_cnt++; if (bus.result !== 64'd42) begin err_cnt++; $display("FAIL single_result: got %0d expected 42", bus.result); end
    vec_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL single_done_gnt: got %b expected 0001", bus.gnt); end
    @(negedge clk);
    vec_cnt++; if ({bus.done, bus.gnt, bus.busy, bus.mu_reset} !== 10'b0000000001) begin err_cnt++; $display("FAIL single_after: got %b expected 0000000001", {bus.done, bus.gnt, bus.busy, bus.mu_reset}); end
  endtask

  task automatic test_all_requesting();
    logic [N-1:0] d;
    logic [2*W-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 32'd10);
    exp_q = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd10};
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(60, d);
      if (n == 4) bus.req = '0;
      e = exp_q.pop_front();
      vec_cnt++; if (d !== (4'b0001 << (n % N))) begin err_cnt++; $display("FAIL all_order[%0d]: got %b expected %b", n, d, 4'b0001 << (n % N)); end
      vec_cnt++; if (bus.result !== e) begin err_cnt++; $display("FAIL all_result[%0d]: got %0d expected %0d", n, bus.result, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [N-1:0] d;
    do_reset();
    set_op(2, 32'd4, 32'd4);
    bus.req = 4'b0100;
    wait_done(40, d);
    set_op(0, 32'd3, 32'd5);
    bus.req = 4'b0101;
    vec_cnt++; if (d !== 4'b0100) begin err_cnt++; $display("FAIL rot_first: got %b expected 0100", d); end
    wait_done(40, d);
    bus.req = 4'b0100;
    vec_cnt++; if (d !== 4'b0001) begin err_cnt++; $display("FAIL rot_wrap: got %b expected 0001", d); end
    vec_cnt++; if (bus.result !== 64'd15) begin err_cnt++; $display("FAIL rot_wrap_result: got %0d expected 15", bus.result); end
    wait_done(40, d);
    bus.req = '0;
    vec_cnt++; if (d !== 4'b0100) begin err_cnt++; $display("FAIL rot_second: got %b expected 0100", d); end
    vec_cnt++; if (bus.result !== 64'd16) begin err_cnt++; $display("FAIL rot_second_result: got %0d expected 16", bus.result); end
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    logic [N-1:0] d;
    logic seen;
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req = 4'b0010;
    wait_run(10, seen);
    set_op(1, 32'd0, 32'hFFFF_FFFF);
    bus.req = '0;
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL opchg_run_seen: got %b expected 1", seen); end
    @(negedge clk);
    vec_cnt++; if (bus.mu_multiplicand !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL opchg_latched: got %h expected ffffffff", bus.mu_multiplicand); end
    wait_done(40, d);
    vec_cnt++; if (d !== 4'b0010) begin err_cnt++; $display("FAIL opchg_done: got %b expected 0010", d); end
    vec_cnt++; if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin err_cnt++; $display("FAIL opchg_result: got %h expected fffffffe00000001", bus.result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d;
    logic seen;
    logic spurious;
    set_op(0, 32'd2, 32'd3);
    bus.req = 4'b0001;
    wait_run(10, seen);
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL rstmid_run_seen: got %b expected 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if ({bus.gnt, bus.mu_run, bus.mu_reset, bus.busy} !== 7'b0000010) begin err_cnt++; $display("FAIL rstmid_ctrl: got %b expected 0000010", {bus.gnt, bus.mu_run, bus.mu_reset, bus.busy}); end
    vec_cnt++; if (bus.result !== 64'd0) begin err_cnt++; $display("FAIL rstmid_result: got %h expected 0", bus.result); end
    set_op(1, 32'd9, 32'd9);
    set_op(2, 32'd4, 32'd4);
    bus.req = 4'b0110;
    spurious = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done !== '0) spurious = 1'b1;
    end
    vec_cnt++; if (spurious !== 1'b0) begin err_cnt++; $display("FAIL rstmid_no_done: got %b expected 0", spurious); end
    rst_n = 1'b1;
    wait_done(40, d);
    bus.req = 4'b0100;
    vec_cnt++; if (d !== 4'b0010) begin err_cnt++; $display("FAIL rstmid_rr_zero: got %b expected 0010", d); end
    vec_cnt++; if (bus.result !== 64'd81) begin err_cnt++; $display("FAIL rstmid_result1: got %0d expected 81", bus.result); end
    wait_done(40, d);
    bus.req = '0;
    vec_cnt++; if (d !== 4'b0100) begin err_cnt++; $display("FAIL rstmid_next: got %b expected 0100", d); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic seen;
    int k;
    logic [N-1:0] d;
    unit_stall = 1'b1;
    set_op(0, 32'd5, 32'd5);
    bus.req = 4'b0001;
    wait_run(10, seen);
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL tmo_run_seen: got %b expected 1", seen); end
`ifdef MULDIV_ARB_TIMEOUT_EN
    d = '0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        d = bus.done;
        break;
      end
    end
    bus.req = '0;
    vec_cnt++; if (k !== TIMEOUT) begin err_cnt++; $display("FAIL tmo_latency: got %0d expected %0d", k, TIMEOUT); end
    vec_cnt++; if (d !== 4'b0001) begin err_cnt++; $display("FAIL tmo_done: got %b expected 0001", d); end
    vec_cnt++; if ({bus.err, bus.result} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin err_cnt++; $display("FAIL tmo_err_result: got %b/%h expected 1/ffffffffffffffff", bus.err, bus.result); end
    @(negedge clk);
    vec_cnt++; if ({bus.err, bus.busy} !== 2'b10) begin err_cnt++; $display("FAIL tmo_sticky: got %b expected 10", {bus.err, bus.busy}); end
`else
    d = '0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done != '0) d = bus.done;
    end
    vec_cnt++; if ({bus.busy, bus.err, d} !== 6'b100000) begin err_cnt++; $display("FAIL tmo_wait_forever: got %b expected 100000", {bus.busy, bus.err, d}); end
    bus.req = '0;
`endif
    unit_stall = 1'b0;
    do_reset();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    unit_stall = 1'b0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    test_reset();
    test_single();
    test_all_requesting();
    test_rotation();
    test_operand_change();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
